dbg_log_arb: RTL

//  Round-robin arbiter merging the log_catted AXI streams of N daisy-chained dbg_guv cores into one log stream.

---
 rtl/dbg_log_arb_pkg.sv | 14 +
 rtl/dbg_log_arb_rr_pick.sv | 30 +++
 rtl/dbg_log_arb.sv | 121 ++++++++++++
 3 files changed

// File: rtl/dbg_log_arb_pkg.sv
// rtl/dbg_log_arb_pkg.sv - shared state encoding and flit width helper for the log arbiter
package dbg_log_arb_pkg;

  typedef enum logic {
    ST_ARB  = 1'b0,
    ST_LOCK = 1'b1
  } arb_state_e;

  // A log flit carries the data word plus its byte-keep bits.
  function automatic int calc_log_w(input int data_width);
    return data_width + data_width / 8;
  endfunction

endpackage

// File: rtl/dbg_log_arb_rr_pick.sv
// rtl/dbg_log_arb_rr_pick.sv - combinational rotating-priority picker
module dbg_log_arb_rr_pick
  import dbg_log_arb_pkg::*;
#(
  parameter int N = 2,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_ptr,
  output logic [W-1:0] o_sel,
  output logic         o_sel_valid
);

  logic [W-1:0] w_idx;

  // Scan from the farthest position back to i_ptr so the nearest requester wins last.
  always_comb begin
    o_sel       = '0;
    o_sel_valid = 1'b0;
    w_idx       = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_idx = W'((int'(i_ptr) + k) % N);
      if (i_req[w_idx]) begin
        o_sel       = w_idx;
        o_sel_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dbg_log_arb.sv
// rtl/dbg_log_arb.sv - round-robin merge of N log streams, packets kept whole, source tagged on TDEST
module dbg_log_arb
  import dbg_log_arb_pkg::*;
#(
  parameter int N_IN       = 2,
  parameter int DATA_WIDTH = 64,
  parameter int PKT_LOCK   = 1,
  parameter int SRC_W      = $clog2(N_IN),
  localparam int LOG_W     = calc_log_w(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_IN*LOG_W-1:0] in_TDATA,
  input  logic [N_IN-1:0]       in_TVALID,
  output logic [N_IN-1:0]       in_TREADY,
  input  logic [N_IN-1:0]       in_TLAST,
  output logic [LOG_W-1:0]      out_TDATA,
  output logic                  out_TVALID,
  input  logic                  out_TREADY,
  output logic                  out_TLAST,
  output logic [SRC_W-1:0]      out_TDEST
);

  arb_state_e       r_state, w_state_nxt;
  logic [SRC_W-1:0] r_rr_ptr, w_rr_ptr_nxt;
  logic [SRC_W-1:0] r_grant, w_grant_nxt;
  logic [SRC_W-1:0] w_pick_sel, w_sel, w_sel_inc;
  logic             w_pick_valid, w_sel_valid, w_ld_en, w_hs, w_sel_last;
  logic [LOG_W-1:0] w_sel_data;
  logic             r_out_valid, r_out_last;
  logic [LOG_W-1:0] r_out_data;
  logic [SRC_W-1:0] r_out_dest;

  dbg_log_arb_rr_pick #(
    .N (N_IN),
    .W (SRC_W)
  ) u_rr_pick (
    .i_req       (in_TVALID),
    .i_ptr       (r_rr_ptr),
    .o_sel       (w_pick_sel),
    .o_sel_valid (w_pick_valid)
  );

  assign w_sel       = (r_state == ST_LOCK) ? r_grant : w_pick_sel;
  assign w_sel_valid = (r_state == ST_LOCK) ? in_TVALID[r_grant] : w_pick_valid;
  assign w_ld_en     = !r_out_valid || out_TREADY;
  // Gating with rst keeps every ready low while the block is held in reset.
  assign w_hs        = rst && w_ld_en && w_sel_valid;
  assign w_sel_inc   = (w_sel == SRC_W'(N_IN - 1)) ? '0 : w_sel + 1'b1;

  always_comb begin
    w_sel_data = '0;
    w_sel_last = 1'b0;
    in_TREADY  = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (w_sel == SRC_W'(i)) begin
        w_sel_data   = in_TDATA[i*LOG_W +: LOG_W];
        w_sel_last   = in_TLAST[i];
        in_TREADY[i] = w_hs;
      end
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_rr_ptr_nxt = r_rr_ptr;
    w_grant_nxt  = r_grant;
    case (r_state)
      ST_ARB: begin
        if (w_hs) begin
          if ((PKT_LOCK != 0) && !w_sel_last) begin
            w_state_nxt = ST_LOCK;
            w_grant_nxt = w_sel;
          end else begin
            w_rr_ptr_nxt = w_sel_inc;
          end
        end
      end
      ST_LOCK: begin
        if (w_hs && w_sel_last) begin
          w_state_nxt  = ST_ARB;
          w_rr_ptr_nxt = w_sel_inc;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_ARB;
      r_rr_ptr <= '0;
      r_grant  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_rr_ptr <= w_rr_ptr_nxt;
      r_grant  <= w_grant_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_data  <= '0;
      r_out_dest  <= '0;
    end else if (w_ld_en) begin
      r_out_valid <= w_hs;
      if (w_hs) begin
        r_out_data <= w_sel_data;
        r_out_last <= w_sel_last;
        r_out_dest <= w_sel;
      end
    end
  end

  assign out_TVALID = r_out_valid;
  assign out_TDATA  = r_out_data;
  assign out_TLAST  = r_out_last;
  assign out_TDEST  = r_out_dest;

endmodule
